// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler
//   Arbitrates the register file's single write port among N_REQ writeback
//   sources (round-robin) and keeps a per-GPR scoreboard of pending writes.
//   Decode uses the scoreboard to stall on RAW hazards, and issue uses it to
//   stall on WAW hazards.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   FLUSH_SD           clears every busy bit and refuses issue this cycle
//   ISSUE_VALID_SD     issue request that will write ISSUE_ADR_SD
//   ISSUE_ADR_SD       destination register of the issuing instruction
//   ISSUE_READY_SD     issue accepted (destination not busy, no flush)
//   RADR1/2_SD         decode source registers
//   BUSY1/2_SR         source register has a pending write
//   REQ_VALID_SW       per-requester writeback valid
//   REQ_ADR_SW         per-requester destination, 6 bits each
//   REQ_DATA_SW        per-requester data, 32 bits each
//   REQ_READY_SW       one-hot grant; a transfer is valid & ready
//   WDATA/WADR_SW      registered register file write data/address
//   WENABLE_SW         registered register file write enable
//   ADR_ERR_SW         pulse: the accepted request targeted address >= N_ARCH
module rf_write_scheduler #(
  parameter int N_REQ  = 3,
  parameter int N_ARCH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 FLUSH_SD,
  input  logic                 ISSUE_VALID_SD,
  input  logic [5:0]           ISSUE_ADR_SD,
  output logic                 ISSUE_READY_SD,
  input  logic [5:0]           RADR1_SD,
  input  logic [5:0]           RADR2_SD,
  output logic                 BUSY1_SR,
  output logic                 BUSY2_SR,
  input  logic [N_REQ-1:0]     REQ_VALID_SW,
  input  logic [6*N_REQ-1:0]   REQ_ADR_SW,
  input  logic [32*N_REQ-1:0]  REQ_DATA_SW,
  output logic [N_REQ-1:0]     REQ_READY_SW,
  output logic [31:0]          WDATA_SW,
  output logic [5:0]           WADR_SW,
  output logic                 WENABLE_SW,
  output logic                 ADR_ERR_SW
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;
  localparam logic [6:0] ARCH_LIM = 7'(N_ARCH);

  ptr_t              ptr_q, ptr_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [5:0]        wadr_q, wadr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [N_ARCH-1:0] busy_q, busy_d;

  logic [N_REQ-1:0]  gnt;
  ptr_t              gidx;
  logic              xfer;
  logic [5:0]        sel_adr;
  logic [31:0]       sel_data;
  logic [63:0]       busy_ext;
  logic              issue_fire;

  // Writable architectural register: not x0 and below N_ARCH.
  function automatic logic in_arch(input logic [5:0] a);
    return (a != '0) && ({1'b0, a} < ARCH_LIM);
  endfunction

  // Zero-extended to the full 6-bit address space so out-of-range reads give 0.
  assign busy_ext = 64'(busy_q);

  assign BUSY1_SR       = busy_ext[RADR1_SD];
  assign BUSY2_SR       = busy_ext[RADR2_SD];
  // Uses the current busy bit, so an issue racing with the clearing write is refused.
  assign ISSUE_READY_SD = ~busy_ext[ISSUE_ADR_SD] & ~FLUSH_SD;
  assign REQ_READY_SW   = gnt;

  assign WENABLE_SW = we_q;
  assign WADR_SW    = wadr_q;
  assign WDATA_SW   = wdata_q;
  assign ADR_ERR_SW = err_q;

  // Round-robin: visit indices ptr, ptr+1, ... (mod N_REQ); first valid wins.
  always_comb begin
    cnt_t cand;
    cand = '0;
    gnt  = '0;
    gidx = '0;
    xfer = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = cnt_t'(ptr_q) + cnt_t'(k);
      if (cand >= cnt_t'(N_REQ)) cand = cand - cnt_t'(N_REQ);
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!xfer && (cnt_t'(i) == cand) && REQ_VALID_SW[i]) begin
          gnt[i] = 1'b1;
          gidx   = ptr_t'(i);
          xfer   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_adr  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_adr  = sel_adr  | REQ_ADR_SW[6*i +: 6];
        sel_data = sel_data | REQ_DATA_SW[32*i +: 32];
      end
    end
  end

  // Pointer, write register and scoreboard next state.
  always_comb begin
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    wadr_d  = wadr_q;
    wdata_d = wdata_q;
    if (xfer) begin
      ptr_d   = (gidx == ptr_t'(N_REQ - 1)) ? '0 : gidx + ptr_t'(1);
      we_d    = in_arch(sel_adr);
      err_d   = ({1'b0, sel_adr} >= ARCH_LIM);
      wadr_d  = sel_adr;
      wdata_d = sel_data;
    end
  end

  assign issue_fire = ISSUE_VALID_SD & ISSUE_READY_SD & in_arch(ISSUE_ADR_SD);

  always_comb begin
    busy_d = busy_q;
    for (int unsigned r = 1; r < N_ARCH; r++) begin
      if (we_q && (wadr_q == 6'(r)))               busy_d[r] = 1'b0;
      if (issue_fire && (ISSUE_ADR_SD == 6'(r)))   busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (FLUSH_SD) busy_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wadr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      err_q   <= err_d;
      wadr_q  <= wadr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
module tb_rf_write_scheduler;
  localparam int N_REQ  = 3;
  localparam int N_ARCH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic                FLUSH_SD, ISSUE_VALID_SD, ISSUE_READY_SD;
  logic [5:0]          ISSUE_ADR_SD, RADR1_SD, RADR2_SD;
  logic                BUSY1_SR, BUSY2_SR;
  logic [N_REQ-1:0]    REQ_VALID_SW, REQ_READY_SW;
  logic [6*N_REQ-1:0]  REQ_ADR_SW;
  logic [32*N_REQ-1:0] REQ_DATA_SW;
  logic [31:0]         WDATA_SW;
  logic [5:0]          WADR_SW;
  logic                WENABLE_SW, ADR_ERR_SW;

  rf_write_scheduler #(.N_REQ(N_REQ), .N_ARCH(N_ARCH)) dut (
    .clk(clk), .reset(reset), .FLUSH_SD(FLUSH_SD),
    .ISSUE_VALID_SD(ISSUE_VALID_SD), .ISSUE_ADR_SD(ISSUE_ADR_SD),
    .ISSUE_READY_SD(ISSUE_READY_SD), .RADR1_SD(RADR1_SD), .RADR2_SD(RADR2_SD),
    .BUSY1_SR(BUSY1_SR), .BUSY2_SR(BUSY2_SR), .REQ_VALID_SW(REQ_VALID_SW),
    .REQ_ADR_SW(REQ_ADR_SW), .REQ_DATA_SW(REQ_DATA_SW), .REQ_READY_SW(REQ_READY_SW),
    .WDATA_SW(WDATA_SW), .WADR_SW(WADR_SW), .WENABLE_SW(WENABLE_SW),
    .ADR_ERR_SW(ADR_ERR_SW)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy[64];
  int          m_ptr;
  bit          m_we, m_err;
  logic [5:0]  m_wadr;
  logic [31:0] m_wdata;
  bit          model_ok = 0;

  function automatic int m_grant();
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (m_ptr + k) % N_REQ;
      if (REQ_VALID_SW[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g, a;
    bit rdy;
    if (reset) begin
      foreach (m_busy[r]) m_busy[r] = 0;
      m_ptr = 0; m_we = 0; m_err = 0; m_wadr = '0; m_wdata = '0;
      model_ok = 1;
    end else if (model_ok) begin
      g   = m_grant();
      rdy = !m_busy[ISSUE_ADR_SD] && !FLUSH_SD;
      if (FLUSH_SD) begin
        foreach (m_busy[r]) m_busy[r] = 0;
      end else begin
        if (m_we) m_busy[m_wadr] = 0;
        if (ISSUE_VALID_SD && rdy && ISSUE_ADR_SD != 0 && ISSUE_ADR_SD < N_ARCH)
          m_busy[ISSUE_ADR_SD] = 1;
      end
      if (g >= 0) begin
        a       = int'(REQ_ADR_SW[6*g +: 6]);
        m_we    = (a != 0) && (a < N_ARCH);
        m_err   = (a >= N_ARCH);
        m_wadr  = REQ_ADR_SW[6*g +: 6];
        m_wdata = REQ_DATA_SW[32*g +: 32];
        m_ptr   = (g + 1) % N_REQ;
      end else begin
        m_we  = 0;
        m_err = 0;
      end
    end
  end

  // Compare every cycle, mid-cycle, against the model.
  always @(negedge clk) begin
    int g;
    logic [N_REQ-1:0] eg;
    if (model_ok) begin
      g  = m_grant();
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      chk("req_ready",   32'(REQ_READY_SW),   32'(eg));
      chk("wenable",     32'(WENABLE_SW),     32'(m_we));
      chk("wadr",        32'(WADR_SW),        32'(m_wadr));
      chk("wdata",       WDATA_SW,            m_wdata);
      chk("adr_err",     32'(ADR_ERR_SW),     32'(m_err));
      chk("busy1",       32'(BUSY1_SR),       32'(m_busy[RADR1_SD]));
      chk("busy2",       32'(BUSY2_SR),       32'(m_busy[RADR2_SD]));
      chk("issue_ready", 32'(ISSUE_READY_SD), 32'(!m_busy[ISSUE_ADR_SD] && !FLUSH_SD));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    FLUSH_SD = 0; ISSUE_VALID_SD = 0; ISSUE_ADR_SD = '0;
    RADR1_SD = '0; RADR2_SD = '0;
    REQ_VALID_SW = '0; REQ_ADR_SW = '0; REQ_DATA_SW = '0;
  endtask

  task automatic set_req(input int i, input logic [5:0] a, input logic [31:0] d);
    REQ_VALID_SW[i]         = 1'b1;
    REQ_ADR_SW[6*i +: 6]    = a;
    REQ_DATA_SW[32*i +: 32] = d;
  endtask

  task automatic all_valid();
    set_req(0, 6'd1, 32'h0000_0011);
    set_req(1, 6'd2, 32'h0000_0022);
    set_req(2, 6'd3, 32'h0000_0033);
  endtask

  logic [2:0] rr_a [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [2:0] rr_b [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001};

  initial begin
    idle();
    reset = 1;
    step(); step();
    reset = 0;

    // reset then idle
    @(negedge clk);
    chk("rst_wen", 32'(WENABLE_SW), 0);
    chk("rst_ready", 32'(REQ_READY_SW), 0);
    chk("rst_busy1", 32'(BUSY1_SR), 0);
    chk("rst_busy2", 32'(BUSY2_SR), 0);
    chk("rst_issue_ready", 32'(ISSUE_READY_SD), 1);
    chk("rst_wadr", 32'(WADR_SW), 0);
    chk("rst_wdata", WDATA_SW, 0);
    chk("rst_err", 32'(ADR_ERR_SW), 0);

    // single write to x5
    step(); ISSUE_VALID_SD = 1; ISSUE_ADR_SD = 6'd5;
    @(negedge clk); chk("sw_issue_ready", 32'(ISSUE_READY_SD), 1);
    step(); idle(); RADR1_SD = 6'd5;
    @(negedge clk); chk("sw_busy_set", 32'(BUSY1_SR), 1);
    step(); set_req(0, 6'd5, 32'hDEADBEEF);
    @(negedge clk); chk("sw_grant", 32'(REQ_READY_SW), 1);
    chk("sw_busy_pre", 32'(BUSY1_SR), 1);
    step(); REQ_VALID_SW = '0;
    @(negedge clk);
    chk("sw_wen", 32'(WENABLE_SW), 1);
    chk("sw_wadr", 32'(WADR_SW), 5);
    chk("sw_wdata", WDATA_SW, 32'hDEADBEEF);
    chk("sw_model_wdata", m_wdata, 32'hDEADBEEF);
    chk("sw_busy_commit", 32'(BUSY1_SR), 1);
    step();
    @(negedge clk);
    chk("sw_busy_clr", 32'(BUSY1_SR), 0);
    chk("sw_wen_off", 32'(WENABLE_SW), 0);
    chk("sw_wdata_hold", WDATA_SW, 32'hDEADBEEF);

    // WAW block on x7 (pointer is now 1)
    step(); idle(); ISSUE_VALID_SD = 1; ISSUE_ADR_SD = 6'd7;
    @(negedge clk); chk("waw_first", 32'(ISSUE_READY_SD), 1);
    step();
    @(negedge clk); chk("waw_second", 32'(ISSUE_READY_SD), 0);
    step(); ISSUE_VALID_SD = 0; set_req(1, 6'd7, 32'h1234_5678);
    @(negedge clk); chk("waw_grant", 32'(REQ_READY_SW), 32'b010);
    chk("waw_blocked", 32'(ISSUE_READY_SD), 0);
    step(); REQ_VALID_SW = '0;
    @(negedge clk);
    chk("waw_wen", 32'(WENABLE_SW), 1);
    chk("waw_wadr", 32'(WADR_SW), 7);
    chk("waw_same_cycle", 32'(ISSUE_READY_SD), 0);
    step();
    @(negedge clk); chk("waw_after", 32'(ISSUE_READY_SD), 1);

    // x0 and out-of-range (pointer is now 2)
    step(); idle(); set_req(2, 6'd0, 32'hAAAA_0000);
    @(negedge clk); chk("x0_grant", 32'(REQ_READY_SW), 32'b100);
    step(); idle(); set_req(0, 6'd40, 32'h0000_BBBB);
    @(negedge clk); chk("x0_wen", 32'(WENABLE_SW), 0);
    chk("x0_err", 32'(ADR_ERR_SW), 0);
    chk("oor_grant", 32'(REQ_READY_SW), 32'b001);
    step(); idle();
    @(negedge clk); chk("oor_wen", 32'(WENABLE_SW), 0);
    chk("oor_err", 32'(ADR_ERR_SW), 1);
    step();
    @(negedge clk); chk("oor_err_pulse", 32'(ADR_ERR_SW), 0);

    // flush clears x3 and x9
    step(); ISSUE_VALID_SD = 1; ISSUE_ADR_SD = 6'd3;
    @(negedge clk); chk("fl_issue3", 32'(ISSUE_READY_SD), 1);
    step(); ISSUE_ADR_SD = 6'd9;
    @(negedge clk); chk("fl_issue9", 32'(ISSUE_READY_SD), 1);
    step(); ISSUE_VALID_SD = 0; ISSUE_ADR_SD = 6'd12;
    RADR1_SD = 6'd3; RADR2_SD = 6'd9; FLUSH_SD = 1;
    @(negedge clk); chk("fl_busy3", 32'(BUSY1_SR), 1);
    chk("fl_busy9", 32'(BUSY2_SR), 1);
    chk("fl_issue_blocked", 32'(ISSUE_READY_SD), 0);
    step(); FLUSH_SD = 0;
    @(negedge clk); chk("fl_clr3", 32'(BUSY1_SR), 0);
    chk("fl_clr9", 32'(BUSY2_SR), 0);
    chk("fl_issue_ok", 32'(ISSUE_READY_SD), 1);

    // round-robin, all valid
    idle(); reset = 1; step(); reset = 0; all_valid();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); chk("rr_all", 32'(REQ_READY_SW), 32'(rr_a[c]));
      step();
    end
    // round-robin, requester 1 drops after its first grant
    idle(); reset = 1; step(); reset = 0; all_valid();
    for (int c = 0; c < 6; c++) begin
      if (c == 2) REQ_VALID_SW[1] = 1'b0;
      @(negedge clk); chk("rr_drop", 32'(REQ_READY_SW), 32'(rr_b[c]));
      step();
    end

    // reset the cycle after a transfer
    idle(); set_req(1, 6'd4, 32'h0000_CAFE);
    @(negedge clk); chk("rm_grant", 32'(REQ_READY_SW), 32'b010);
    step(); idle(); reset = 1;
    @(negedge clk); chk("rm_wen_before", 32'(WENABLE_SW), 1);
    step(); reset = 0; all_valid();
    @(negedge clk); chk("rm_wen_after", 32'(WENABLE_SW), 0);
    chk("rm_ptr_zero", 32'(REQ_READY_SW), 32'b001);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step();
      reset          = ($urandom_range(0, 199) == 0);
      FLUSH_SD       = ($urandom_range(0, 24) == 0);
      ISSUE_VALID_SD = $urandom_range(0, 1);
      ISSUE_ADR_SD   = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(32, 63))
                                                   : 6'($urandom_range(0, 12));
      RADR1_SD       = 6'($urandom_range(0, 15));
      RADR2_SD       = 6'($urandom_range(0, 63));
      REQ_VALID_SW   = N_REQ'($urandom);
      for (int i = 0; i < N_REQ; i++) begin
        REQ_ADR_SW[6*i +: 6]    = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(32, 63))
                                                              : 6'($urandom_range(0, 12));
        REQ_DATA_SW[32*i +: 32] = $urandom;
      end
    end
    step(); reset = 0; idle();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
